video_timing_gen_prog: RTL and testbench

- Runtime-programmable successor to the fixed-format sync generator.
- Produces hsync/vsync/de/field, pixel coordinates and frame/line strobes from per-field timing registers.
- Register changes are staged and take effect only at a frame boundary.
- Sits between the pixel-clock domain control interface and the video output / pattern generator.

---
 rtl/video_timing_pkg.sv | 49 ++++
 rtl/video_timing_axis.sv | 52 +++++
 rtl/video_timing_gen_prog.sv | 215 +++++++++++++++++++++
 tb/tb_video_timing_gen_prog.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and defaults for the programmable video timing generator.
// A timing set is one complete description of line and field geometry plus mode bits.
package video_timing_pkg;

    localparam int VT_CNT_W = 13;

    localparam int VT_DEF_H_ACTIVE  = 1280;
    localparam int VT_DEF_H_FP      = 440;
    localparam int VT_DEF_H_SYNC    = 40;
    localparam int VT_DEF_H_BP      = 220;
    localparam int VT_DEF_V_ACTIVE  = 720;
    localparam int VT_DEF_V_FP      = 5;
    localparam int VT_DEF_V_SYNC    = 5;
    localparam int VT_DEF_V_BP      = 20;
    localparam int VT_DEF_INTERLACE = 0;
    localparam int VT_DEF_HS_POL    = 1;
    localparam int VT_DEF_VS_POL    = 1;

    typedef struct packed {
        logic [VT_CNT_W-1:0] h_active;
        logic [VT_CNT_W-1:0] h_fp;
        logic [VT_CNT_W-1:0] h_sync;
        logic [VT_CNT_W-1:0] h_bp;
        logic [VT_CNT_W-1:0] v_active;
        logic [VT_CNT_W-1:0] v_fp;
        logic [VT_CNT_W-1:0] v_sync;
        logic [VT_CNT_W-1:0] v_bp;
        logic                interlace;
        logic                hs_pol;
        logic                vs_pol;
    } timing_t;

    // Totals use two guard bits so oversize sets cannot wrap into a legal-looking value.
    function automatic logic timing_valid(timing_t t);
        logic [VT_CNT_W+1:0] h_tot;
        logic [VT_CNT_W+1:0] v_tot_p1;
        logic [VT_CNT_W+1:0] lim;
        h_tot    = (VT_CNT_W+2)'(t.h_active) + (VT_CNT_W+2)'(t.h_fp)
                 + (VT_CNT_W+2)'(t.h_sync)   + (VT_CNT_W+2)'(t.h_bp);
        v_tot_p1 = (VT_CNT_W+2)'(t.v_active) + (VT_CNT_W+2)'(t.v_fp)
                 + (VT_CNT_W+2)'(t.v_sync)   + (VT_CNT_W+2)'(t.v_bp)
                 + (VT_CNT_W+2)'(1);
        lim      = {2'b00, {VT_CNT_W{1'b1}}};
        return (t.h_active != '0) && (t.h_sync != '0) &&
               (t.v_active != '0) && (t.v_sync != '0) &&
               (h_tot <= lim) && (v_tot_p1 <= lim);
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One timing axis: a wrapping counter with active/sync region decode.
// Region order is active, front porch, sync, back porch, then an optional extra count.
module video_timing_axis #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         advance_i,
    input  logic         extra_i,
    input  logic [W-1:0] active_len_i,
    input  logic [W-1:0] fp_len_i,
    input  logic [W-1:0] sync_len_i,
    input  logic [W-1:0] bp_len_i,
    output logic [W-1:0] count_o,
    output logic         active_o,
    output logic         sync_raw_o,
    output logic         last_o
);

    logic [W-1:0] count_q, count_d;
    logic [W+1:0] cnt_w, sync_start, sync_end, last_idx;

    always_comb begin
        cnt_w      = (W+2)'(count_q);
        sync_start = (W+2)'(active_len_i) + (W+2)'(fp_len_i);
        sync_end   = sync_start + (W+2)'(sync_len_i);
        last_idx   = sync_end + (W+2)'(bp_len_i) + (W+2)'(extra_i) - (W+2)'(1);

        active_o   = cnt_w < (W+2)'(active_len_i);
        sync_raw_o = (cnt_w >= sync_start) && (cnt_w < sync_end);
        last_o     = cnt_w == last_idx;

        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/video_timing_gen_prog.sv
// Programmable sync generator: staged timing registers applied at frame boundaries,
// registered hsync/vsync/de/field, pixel coordinates and frame/line strobes.
module video_timing_gen_prog
    import video_timing_pkg::*;
#(
    parameter int CNT_W         = VT_CNT_W,
    parameter int DEF_H_ACTIVE  = VT_DEF_H_ACTIVE,
    parameter int DEF_H_FP      = VT_DEF_H_FP,
    parameter int DEF_H_SYNC    = VT_DEF_H_SYNC,
    parameter int DEF_H_BP      = VT_DEF_H_BP,
    parameter int DEF_V_ACTIVE  = VT_DEF_V_ACTIVE,
    parameter int DEF_V_FP      = VT_DEF_V_FP,
    parameter int DEF_V_SYNC    = VT_DEF_V_SYNC,
    parameter int DEF_V_BP      = VT_DEF_V_BP,
    parameter int DEF_INTERLACE = VT_DEF_INTERLACE,
    parameter int DEF_HS_POL    = VT_DEF_HS_POL,
    parameter int DEF_VS_POL    = VT_DEF_VS_POL
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_interlace,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    input  logic             cfg_update,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             field,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             line_start
);

    localparam int SW = CNT_W + 2;

    localparam timing_t DEF_SET = '{
        h_active:  VT_CNT_W'(DEF_H_ACTIVE),
        h_fp:      VT_CNT_W'(DEF_H_FP),
        h_sync:    VT_CNT_W'(DEF_H_SYNC),
        h_bp:      VT_CNT_W'(DEF_H_BP),
        v_active:  VT_CNT_W'(DEF_V_ACTIVE),
        v_fp:      VT_CNT_W'(DEF_V_FP),
        v_sync:    VT_CNT_W'(DEF_V_SYNC),
        v_bp:      VT_CNT_W'(DEF_V_BP),
        interlace: 1'(DEF_INTERLACE),
        hs_pol:    1'(DEF_HS_POL),
        vs_pol:    1'(DEF_VS_POL)
    };

    timing_t cfg_in, staging_q, staging_d, shadow_q, shadow_d;
    logic    pending_q, pending_d, cfg_ok, frame_end, apply, restart;
    logic    field_q, field_d;

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             h_act, h_sync_raw, h_last;
    logic             v_act, v_sync_raw, v_last;
    logic [SW-1:0]    hc_w, vc_w, h_half, vs_start, vs_end;
    logic             vs_half_raw, vs_raw;

    logic             ack_q, err_q, hsync_q, hsync_d, vsync_q, vsync_d;
    logic             de_q, de_d, field_o_q, field_o_d;
    logic             fs_q, fs_d, ls_q, ls_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

    assign cfg_in = '{
        h_active:  cfg_h_active,
        h_fp:      cfg_h_fp,
        h_sync:    cfg_h_sync,
        h_bp:      cfg_h_bp,
        v_active:  cfg_v_active,
        v_fp:      cfg_v_fp,
        v_sync:    cfg_v_sync,
        v_bp:      cfg_v_bp,
        interlace: cfg_interlace,
        hs_pol:    cfg_hs_pol,
        vs_pol:    cfg_vs_pol
    };

    video_timing_axis #(.W(CNT_W)) u_h_axis (
        .clk         (pclk),
        .rst_n       (rst_n),
        .clear_i     (restart),
        .advance_i   (enable),
        .extra_i     (1'b0),
        .active_len_i(shadow_q.h_active),
        .fp_len_i    (shadow_q.h_fp),
        .sync_len_i  (shadow_q.h_sync),
        .bp_len_i    (shadow_q.h_bp),
        .count_o     (hcnt),
        .active_o    (h_act),
        .sync_raw_o  (h_sync_raw),
        .last_o      (h_last)
    );

    // Field 1 of an interlaced frame carries one extra blanking line after the back porch.
    video_timing_axis #(.W(CNT_W)) u_v_axis (
        .clk         (pclk),
        .rst_n       (rst_n),
        .clear_i     (restart),
        .advance_i   (h_last),
        .extra_i     (shadow_q.interlace & field_q),
        .active_len_i(shadow_q.v_active),
        .fp_len_i    (shadow_q.v_fp),
        .sync_len_i  (shadow_q.v_sync),
        .bp_len_i    (shadow_q.v_bp),
        .count_o     (vcnt),
        .active_o    (v_act),
        .sync_raw_o  (v_sync_raw),
        .last_o      (v_last)
    );

    always_comb begin
        cfg_ok    = timing_valid(cfg_in);
        frame_end = enable & h_last & v_last & (~shadow_q.interlace | field_q);
        apply     = pending_q & (frame_end | ~enable);
        restart   = apply | ~enable;

        // A capture in the apply cycle re-arms pending with the new set.
        shadow_d  = apply ? staging_q : shadow_q;
        staging_d = (cfg_update & cfg_ok) ? cfg_in : staging_q;
        pending_d = pending_q;
        if (cfg_update) begin
            pending_d = cfg_ok;
        end else if (apply) begin
            pending_d = 1'b0;
        end

        field_d = field_q;
        if (restart) begin
            field_d = 1'b0;
        end else if (h_last & v_last) begin
            field_d = shadow_q.interlace & ~field_q;
        end
    end

    // Field-1 vsync is shifted by half a line: compare (line, pixel) positions.
    always_comb begin
        hc_w     = SW'(hcnt);
        vc_w     = SW'(vcnt);
        h_half   = (SW'(shadow_q.h_active) + SW'(shadow_q.h_fp)
                  + SW'(shadow_q.h_sync)   + SW'(shadow_q.h_bp)) >> 1;
        vs_start = SW'(shadow_q.v_active) + SW'(shadow_q.v_fp);
        vs_end   = vs_start + SW'(shadow_q.v_sync);
        vs_half_raw = ((vc_w > vs_start) || ((vc_w == vs_start) && (hc_w >= h_half))) &&
                      ((vc_w < vs_end)   || ((vc_w == vs_end)   && (hc_w <  h_half)));
        vs_raw   = (shadow_q.interlace & field_q) ? vs_half_raw : v_sync_raw;

        de_d      = enable & h_act & v_act;
        hsync_d   = (enable & h_sync_raw) ~^ shadow_q.hs_pol;
        vsync_d   = (enable & vs_raw) ~^ shadow_q.vs_pol;
        field_o_d = enable & field_q;
        x_d       = de_d ? hcnt : '0;
        y_d       = de_d ? vcnt : '0;
        ls_d      = de_d & (hcnt == '0);
        fs_d      = ls_d & (vcnt == '0) & ~field_q;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= DEF_SET;
            staging_q <= DEF_SET;
            pending_q <= 1'b0;
            field_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            hsync_q   <= ~DEF_SET.hs_pol;
            vsync_q   <= ~DEF_SET.vs_pol;
            de_q      <= 1'b0;
            field_o_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            pending_q <= pending_d;
            field_q   <= field_d;
            ack_q     <= apply;
            err_q     <= cfg_update & ~cfg_ok;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            field_o_q <= field_o_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fs_q      <= fs_d;
            ls_q      <= ls_d;
        end
    end

    assign cfg_ack     = ack_q;
    assign cfg_err     = err_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign field       = field_o_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule

// File: tb/tb_video_timing_gen_prog.sv
// Directed bench for video_timing_gen_prog: per-cycle comparison of all outputs
// against a small position model of the programmed timing.
module tb_video_timing_gen_prog;

    localparam int W = 13;

    logic         pclk = 1'b0;
    logic         rst_n, enable, cfg_update;
    logic [W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic         cfg_interlace, cfg_hs_pol, cfg_vs_pol;
    logic         cfg_ack, cfg_err, hsync, vsync, de, field, frame_start, line_start;
    logic [W-1:0] x, y;

    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_ha, m_hfp, m_hs, m_hbp, m_va, m_vfp, m_vs, m_vbp;
    logic m_il, m_hp, m_vp;
    int   mh, mv;
    logic mf;

    video_timing_gen_prog dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .enable       (enable),
        .cfg_h_active (cfg_h_active),
        .cfg_h_fp     (cfg_h_fp),
        .cfg_h_sync   (cfg_h_sync),
        .cfg_h_bp     (cfg_h_bp),
        .cfg_v_active (cfg_v_active),
        .cfg_v_fp     (cfg_v_fp),
        .cfg_v_sync   (cfg_v_sync),
        .cfg_v_bp     (cfg_v_bp),
        .cfg_interlace(cfg_interlace),
        .cfg_hs_pol   (cfg_hs_pol),
        .cfg_vs_pol   (cfg_vs_pol),
        .cfg_update   (cfg_update),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .field        (field),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .line_start   (line_start)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cfg(input int ha, input int hfp, input int hs, input int hbp,
                           input int va, input int vfp, input int vs, input int vbp,
                           input logic il, input logic hp, input logic vp);
        cfg_h_active = W'(ha);  cfg_h_fp = W'(hfp);  cfg_h_sync = W'(hs);  cfg_h_bp = W'(hbp);
        cfg_v_active = W'(va);  cfg_v_fp = W'(vfp);  cfg_v_sync = W'(vs);  cfg_v_bp = W'(vbp);
        cfg_interlace = il;     cfg_hs_pol = hp;     cfg_vs_pol = vp;
    endtask

    task automatic load_model();
        m_ha = int'(cfg_h_active); m_hfp = int'(cfg_h_fp); m_hs = int'(cfg_h_sync); m_hbp = int'(cfg_h_bp);
        m_va = int'(cfg_v_active); m_vfp = int'(cfg_v_fp); m_vs = int'(cfg_v_sync); m_vbp = int'(cfg_v_bp);
        m_il = cfg_interlace; m_hp = cfg_hs_pol; m_vp = cfg_vs_pol;
    endtask

    function automatic logic [33:0] got_vec();
        return {cfg_ack, cfg_err, hsync, vsync, de, field, frame_start, line_start, x, y};
    endfunction

    // Expected outputs one cycle after the counters sat at (h, v) in field f.
    function automatic logic [33:0] exp_out(input int h, input int v, input logic f);
        int   ht, p, s, e;
        logic de_e, hs_r, vs_r, ls_e, fs_e;
        ht   = m_ha + m_hfp + m_hs + m_hbp;
        de_e = (h < m_ha) && (v < m_va);
        hs_r = (h >= m_ha + m_hfp) && (h < m_ha + m_hfp + m_hs);
        p    = v * ht + h;
        s    = (m_va + m_vfp) * ht;
        e    = (m_va + m_vfp + m_vs) * ht;
        if (f) begin
            s = s + ht / 2;
            e = e + ht / 2;
        end
        vs_r = (p >= s) && (p < e);
        ls_e = de_e && (h == 0);
        fs_e = ls_e && (v == 0) && !f;
        return {1'b0, 1'b0, hs_r ~^ m_hp, vs_r ~^ m_vp, de_e, f, fs_e, ls_e,
                de_e ? W'(h) : W'(0), de_e ? W'(v) : W'(0)};
    endfunction

    task automatic advance_model();
        int ht, vt;
        ht = m_ha + m_hfp + m_hs + m_hbp;
        vt = m_va + m_vfp + m_vs + m_vbp + ((m_il && mf) ? 1 : 0);
        mh++;
        if (mh == ht) begin
            mh = 0;
            mv++;
            if (mv == vt) begin
                mv = 0;
                mf = m_il ? ~mf : 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_ack);
        check_eq(tag, 64'(got_vec()), 64'({exp_ack, 1'b0, ~m_hp, ~m_vp, 4'b0000, 26'd0}));
    endtask

    // n running cycles; cfg_update is pulsed into iteration upd_at, ack/err expected at given iterations.
    task automatic run(input int n, input int upd_at, input int ack_at, input int err_at);
        logic [33:0] e;
        for (int i = 0; i < n; i++) begin
            if (i == upd_at) cfg_update = 1'b1;
            step();
            cfg_update = 1'b0;
            e     = exp_out(mh, mv, mf);
            e[33] = (i == ack_at);
            e[32] = (i == err_at);
            check_eq($sformatf("run[%0d] h%0d v%0d f%0d", i, mh, mv, mf), 64'(got_vec()), 64'(e));
            if (i == ack_at) begin
                load_model();
                mh = 0; mv = 0; mf = 1'b0;
            end else begin
                advance_model();
            end
        end
    endtask

    task automatic program_idle(input string tag);
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check_eq({tag, "_capture"}, 64'({cfg_ack, cfg_err}), 64'(2'b00));
        step();
        check_eq({tag, "_ack"}, 64'({cfg_ack, cfg_err}), 64'(2'b10));
        load_model();
        step();
        check_idle({tag, "_idle"}, 1'b0);
    endtask

    task automatic start_run();
        enable = 1'b1;
        mh = 0; mv = 0; mf = 1'b0;
    endtask

    task automatic stop_run(input string tag);
        enable = 1'b0;
        step();
        check_idle(tag, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_update = 1'b0;
        set_cfg(1280, 440, 40, 220, 720, 5, 5, 20, 1'b0, 1'b1, 1'b1);
        load_model();
        mh = 0; mv = 0; mf = 1'b0;
        #12;
        check_eq("reset", 64'(got_vec()), 64'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        step();
        check_idle("post_reset", 1'b0);

        // Progressive 16x8 test mode.
        set_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b1, 1'b1);
        program_idle("prog");
        start_run();
        run(256, -1, -1, -1);

        // Interlaced: fields of 128 and 144 cycles.
        stop_run("stop_prog");
        set_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1, 1'b1);
        program_idle("ilace");
        start_run();
        run(544, -1, -1, -1);

        // Mid-frame update takes effect only after the last pixel of the frame.
        stop_run("stop_ilace");
        set_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b1, 1'b1);
        program_idle("prog2");
        start_run();
        cfg_h_active = W'(4);
        run(256, 40, 127, -1);

        // Rejected sets: zero sync width, then h_tot of 8192.
        cfg_h_sync = W'(0);
        run(200, 10, -1, 10);
        set_cfg(8000, 100, 42, 50, 4, 1, 2, 1, 1'b0, 1'b1, 1'b1);
        run(100, 5, -1, 5);

        // Active-low syncs, idle high while disabled.
        stop_run("stop_err");
        set_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0, 1'b0);
        program_idle("pol");
        start_run();
        run(128, -1, -1, -1);
        stop_run("stop_pol");

        // Reset mid-line with a pending update.
        cfg_h_active = W'(4);
        start_run();
        run(20, 3, -1, -1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", 64'(got_vec()), 64'd0);
        enable = 1'b0;
        set_cfg(1280, 440, 40, 220, 720, 5, 5, 20, 1'b0, 1'b1, 1'b1);
        load_model();
        @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle($sformatf("rst_idle[%0d]", i), 1'b0);
        end
        start_run();
        run(5940, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
